wb_arbiter: RTL and testbench

- Round-robin Wishbone (classic) arbiter. Merges NM bus masters onto the single master port of the address-decoding router, so it sits directly upstream of the router.
- A grant is held for the whole of the owning master's CYC assertion.
- A built-in watchdog terminates stalled transfers with an error response, so an unresponsive slave cannot hang a master.

---
 rtl/wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: NM masters onto one router port, grant held for the owner's CYC.
// Latency: one cycle from CYC rise to grant; the slave path is combinational while owned.
// Backpressure: masters that are not granted see no ACK/ERR; the watchdog errors out stalled strobes.
module wb_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NM-1:0]    i_mcyc,
    input  logic [NM-1:0]    i_mstb,
    input  logic [NM-1:0]    i_mwe,
    input  logic [NM*AW-1:0] i_maddr,
    input  logic [NM*DW-1:0] i_mdata,
    input  logic [NM*SW-1:0] i_msel,
    output logic [NM-1:0]    o_mack,
    output logic [DW-1:0]    o_mdata,
    output logic [NM-1:0]    o_merr,
    output logic             o_scyc,
    output logic             o_sstb,
    output logic             o_swe,
    output logic [AW-1:0]    o_saddr,
    output logic [DW-1:0]    o_sdata,
    output logic [SW-1:0]    o_ssel,
    input  logic             i_sack,
    input  logic [DW-1:0]    i_sdata,
    input  logic             i_serr,
    output logic [NM-1:0]    o_grant
);

    localparam int GW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   p_q, p_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic [NM-1:0]   req_hi;
    logic [GW-1:0]   pick_lo, pick_hi, pick;
    logic            pick_lo_vld, pick_hi_vld;

    logic            owned;
    logic            cyc_g, stb_g, we_g;
    logic [AW-1:0]   addr_g;
    logic [DW-1:0]   data_g;
    logic [SW-1:0]   sel_g;
    logic            wd_fire;

    assign owned   = (state_q == OWNED);
    assign o_mdata = i_sdata;

    // Requests at or above the pointer win; otherwise wrap to the lowest requester.
    always_comb begin
        req_hi      = i_mcyc & ~((NM'(1) << p_q) - NM'(1));
        pick_lo     = '0;
        pick_hi     = '0;
        pick_lo_vld = 1'b0;
        pick_hi_vld = 1'b0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (i_mcyc[i]) begin
                pick_lo     = GW'(i);
                pick_lo_vld = 1'b1;
            end
            if (req_hi[i]) begin
                pick_hi     = GW'(i);
                pick_hi_vld = 1'b1;
            end
        end
        pick = pick_hi_vld ? pick_hi : pick_lo;
    end

    always_comb begin
        cyc_g  = 1'b0;
        stb_g  = 1'b0;
        we_g   = 1'b0;
        addr_g = '0;
        data_g = '0;
        sel_g  = '0;
        for (int i = 0; i < NM; i++) begin
            if (g_q == GW'(i)) begin
                cyc_g  = i_mcyc[i];
                stb_g  = i_mstb[i];
                we_g   = i_mwe[i];
                addr_g = i_maddr[i*AW +: AW];
                data_g = i_mdata[i*DW +: DW];
                sel_g  = i_msel[i*SW +: SW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (pick_lo_vld) begin
                    g_d     = pick;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    p_d     = (g_q == GW'(NM - 1)) ? '0 : g_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A slave response always beats the timeout in the same cycle.
    always_comb begin
        wd_fire = (TIMEOUT > 0) && owned && stb_g && (wd_q == WDW'(TIMEOUT))
                  && !i_sack && !i_serr;
        wd_d = wd_q;
        if (!owned || !stb_g || i_sack || i_serr || wd_fire) begin
            wd_d = '0;
        end else if (wd_q != WDW'(TIMEOUT)) begin
            wd_d = wd_q + WDW'(1);
        end
    end

    always_comb begin
        o_scyc  = 1'b0;
        o_sstb  = 1'b0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        o_grant = '0;
        o_mack  = '0;
        o_merr  = '0;
        if (owned) begin
            o_scyc  = cyc_g;
            o_sstb  = stb_g;
            o_swe   = we_g;
            o_saddr = addr_g;
            o_sdata = data_g;
            o_ssel  = sel_g;
            for (int i = 0; i < NM; i++) begin
                if (g_q == GW'(i)) begin
                    o_grant[i] = 1'b1;
                    o_mack[i]  = i_sack;
                    o_merr[i]  = i_serr | wd_fire;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for arbitration/pass-through plus
// hand sequences for watchdog, ACK/timeout race and reset mid-transfer.
module tb_wb_arbiter;

    localparam int NV = 15;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  mcyc, mstb, mwe;
    logic [63:0] maddr, mdat;
    logic [7:0]  msel;
    logic        sack, serr;
    logic [31:0] sdata;

    logic [1:0]  mack, merr, grant;
    logic [31:0] mdata_o, saddr, sdata_o;
    logic        scyc, sstb, swe;
    logic [3:0]  ssel;

    logic [1:0]  z_mack, z_merr, z_grant;
    logic [31:0] z_mdata_o, z_saddr, z_sdata_o;
    logic        z_scyc, z_sstb, z_swe;
    logic [3:0]  z_ssel;

    wb_arbiter #(.NM(2), .AW(32), .DW(32), .SW(4), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe),
        .i_maddr(maddr), .i_mdata(mdat), .i_msel(msel), .o_mack(mack),
        .o_mdata(mdata_o), .o_merr(merr), .o_scyc(scyc), .o_sstb(sstb),
        .o_swe(swe), .o_saddr(saddr), .o_sdata(sdata_o), .o_ssel(ssel),
        .i_sack(sack), .i_sdata(sdata), .i_serr(serr), .o_grant(grant)
    );

    wb_arbiter #(.NM(2), .AW(32), .DW(32), .SW(4), .TIMEOUT(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe),
        .i_maddr(maddr), .i_mdata(mdat), .i_msel(msel), .o_mack(z_mack),
        .o_mdata(z_mdata_o), .o_merr(z_merr), .o_scyc(z_scyc), .o_sstb(z_sstb),
        .o_swe(z_swe), .o_saddr(z_saddr), .o_sdata(z_sdata_o), .o_ssel(z_ssel),
        .i_sack(sack), .i_sdata(sdata), .i_serr(serr), .o_grant(z_grant)
    );

    typedef struct {
        logic [1:0]  mcyc;
        logic [1:0]  mstb;
        logic        sack;
        logic        serr;
        logic        scyc;
        logic        sstb;
        logic        swe;
        logic [31:0] saddr;
        logic [1:0]  grant;
        logic [1:0]  mack;
        logic [1:0]  merr;
    } vec_t;

    vec_t v [NV];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [1:0] s, input logic a, input logic e);
        mcyc = c;
        mstb = s;
        sack = a;
        serr = e;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    logic [31:0] exp_sdata;
    logic [3:0]  exp_ssel;

    initial begin
        rst   = 1'b1;
        mwe   = 2'b01;
        maddr = {32'h2000_0008, 32'h1000_0004};
        mdat  = {32'hBBBB_1111, 32'hAAAA_0000};
        msel  = {4'h3, 4'hF};
        sdata = 32'h0;
        drive(2'b00, 2'b00, 1'b0, 1'b0);

        //          mcyc   mstb   ack   err   scyc  sstb  swe   saddr          grant  mack   merr
        v[0]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00};
        v[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 2'b01, 2'b00, 2'b00};
        v[2]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 2'b01, 2'b00, 2'b00};
        v[3]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 2'b01, 2'b01, 2'b00};
        v[4]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 2'b01, 2'b00, 2'b00};
        v[5]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 2'b01, 2'b00, 2'b00};
        v[6]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00};
        v[7]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000_0008, 2'b10, 2'b00, 2'b00};
        v[8]  = '{2'b11, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000_0008, 2'b10, 2'b10, 2'b00};
        v[9]  = '{2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h2000_0008, 2'b10, 2'b10, 2'b10};
        v[10] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2000_0008, 2'b10, 2'b00, 2'b00};
        v[11] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00};
        v[12] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 2'b01, 2'b00, 2'b00};
        v[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0004, 2'b01, 2'b00, 2'b00};
        v[14] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00};

        tick;
        @(negedge clk);
        chk("rst grant", grant, 2'b00);
        chk("rst scyc", scyc, 1'b0);
        chk("rst mack", mack, 2'b00);
        chk("rst merr", merr, 2'b00);
        do_reset;

        for (int i = 0; i < NV; i++) begin
            drive(v[i].mcyc, v[i].mstb, v[i].sack, v[i].serr);
            sdata = 32'h5A00_0000 | i;
            case (v[i].grant)
                2'b01:   begin exp_sdata = 32'hAAAA_0000; exp_ssel = 4'hF; end
                2'b10:   begin exp_sdata = 32'hBBBB_1111; exp_ssel = 4'h3; end
                default: begin exp_sdata = 32'h0;         exp_ssel = 4'h0; end
            endcase
            @(negedge clk);
            chk($sformatf("v%0d scyc", i), scyc, v[i].scyc);
            chk($sformatf("v%0d sstb", i), sstb, v[i].sstb);
            chk($sformatf("v%0d swe", i), swe, v[i].swe);
            chk($sformatf("v%0d saddr", i), saddr, v[i].saddr);
            chk($sformatf("v%0d grant", i), grant, v[i].grant);
            chk($sformatf("v%0d mack", i), mack, v[i].mack);
            chk($sformatf("v%0d merr", i), merr, v[i].merr);
            chk($sformatf("v%0d sdata", i), sdata_o, exp_sdata);
            chk($sformatf("v%0d ssel", i), ssel, exp_ssel);
            chk($sformatf("v%0d mdata", i), mdata_o, 32'h5A00_0000 | i);
            tick;
        end

        // Watchdog: master 1 strobes forever, slave silent.
        do_reset;
        drive(2'b10, 2'b10, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("wd c%0d merr", c), merr, (c == 5) ? 2'b10 : 2'b00);
            chk($sformatf("wd c%0d grant", c), grant, (c == 0) ? 2'b00 : 2'b10);
            chk($sformatf("wd0 c%0d merr", c), z_merr, 2'b00);
            chk($sformatf("wd0 c%0d grant", c), z_grant, (c == 0) ? 2'b00 : 2'b10);
            tick;
        end

        // ACK lands in the cycle the counter reaches the limit.
        do_reset;
        for (int c = 0; c < 8; c++) begin
            drive(2'b01, 2'b01, (c == 5), 1'b0);
            @(negedge clk);
            chk($sformatf("race c%0d mack", c), mack, (c == 5) ? 2'b01 : 2'b00);
            chk($sformatf("race c%0d merr", c), merr, 2'b00);
            tick;
        end

        // Reset while master 1 owns the bus with the pointer sitting at 1.
        do_reset;
        drive(2'b01, 2'b01, 1'b0, 1'b0);
        tick;
        tick;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        tick;
        drive(2'b10, 2'b10, 1'b0, 1'b0);
        tick;
        tick;
        @(negedge clk);
        chk("rmid pre grant", grant, 2'b10);
        drive(2'b11, 2'b11, 1'b0, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sack = 1'b1;
        @(negedge clk);
        chk("rmid scyc", scyc, 1'b0);
        chk("rmid sstb", sstb, 1'b0);
        chk("rmid grant", grant, 2'b00);
        chk("rmid mack", mack, 2'b00);
        tick;
        sack = 1'b0;
        @(negedge clk);
        chk("rmid p0 grant", grant, 2'b01);
        drive(2'b10, 2'b10, 1'b0, 1'b0);
        tick;
        @(negedge clk);
        chk("rmid gap grant", grant, 2'b00);
        tick;
        @(negedge clk);
        chk("rmid m1 grant", grant, 2'b10);
        chk("rmid m1 saddr", saddr, 32'h2000_0008);
        chk("rmid m1 scyc", scyc, 1'b1);
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        tick;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
